// File: rtl/scan_sequencer.sv
`timescale 1ns/1ps
// Cube-state scan sequencer: requests setup moves, debounces the colour sensors,
// assembles the packed cube state and validates the colour counts.
module scan_sequencer #(
    parameter int NUM_OBS     = 48,
    parameter int COLOR_W     = 3,
    parameter int SPLIT       = 24,
    parameter int SAMPLES     = 3,
    parameter int MAX_RETRIES = 4,
    parameter int TIMEOUT     = 1000000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [COLOR_W-1:0]             edge_color_sensor,
    input  logic [COLOR_W-1:0]             corner_color_sensor,
    input  logic                           color_sensor_stable,
    output logic                           send_setup_moves,
    output logic [$clog2(NUM_OBS+1)-1:0]   counter,
    output logic [(NUM_OBS+6)*COLOR_W-1:0] cubestate_output,
    output logic                           cubestate_determined,
    output logic                           scan_error,
    output logic [1:0]                     error_code
);

    // state | meaning: SETUP idle/clear, PREP setup pulse, WAIT await stable sensor,
    // SAMPLE debounce, FINAL restore pulse, CHECK count colours, DONE valid, ERROR fault held
    localparam logic [2:0] ST_SETUP  = 3'd0;
    localparam logic [2:0] ST_PREP   = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_FINAL  = 3'd4;
    localparam logic [2:0] ST_CHECK  = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;
    localparam logic [2:0] ST_ERROR  = 3'd7;

    localparam int CNT_W = $clog2(NUM_OBS+1);
    localparam int STK_W = NUM_OBS*COLOR_W;
    localparam int CUB_W = (NUM_OBS+6)*COLOR_W;
    localparam int TMR_W = $clog2(TIMEOUT+1);
    localparam int SMP_W = $clog2(SAMPLES+1);
    localparam int RTY_W = $clog2(MAX_RETRIES+1);

    localparam logic [CNT_W-1:0]   LAST_IDX  = CNT_W'(NUM_OBS-1);
    localparam logic [CNT_W-1:0]   SPLIT_IDX = CNT_W'(SPLIT);
    localparam logic [CNT_W-1:0]   PER_COLOR = CNT_W'(NUM_OBS/6);
    localparam logic [TMR_W-1:0]   TMR_INIT  = TMR_W'(TIMEOUT-1);
    localparam logic [SMP_W-1:0]   SMP_LAST  = SMP_W'(SAMPLES-1);
    localparam logic [RTY_W-1:0]   RTY_MAX   = RTY_W'(MAX_RETRIES);
    localparam logic [COLOR_W-1:0] MAX_CODE  = COLOR_W'(5);
    localparam logic [6*COLOR_W-1:0] CENTRES = {COLOR_W'(5), COLOR_W'(4), COLOR_W'(3),
                                                COLOR_W'(2), COLOR_W'(1), COLOR_W'(0)};

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [STK_W-1:0]   stickers_q, stickers_d;
    logic [CUB_W-1:0]   cube_q, cube_d;
    logic               determined_q, determined_d;
    logic               error_q, error_d;
    logic [1:0]         code_q, code_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [SMP_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic [RTY_W-1:0]   retry_q, retry_d, retry_inc;
    logic [COLOR_W-1:0] ref_q, ref_d;
    logic [CNT_W-1:0]   chk_idx_q, chk_idx_d;
    logic               invalid_q, invalid_d, invalid_next;
    logic [CNT_W-1:0]   tally_q [6];
    logic [CNT_W-1:0]   tally_d [6];
    logic [CNT_W-1:0]   tally_next [6];

    logic [COLOR_W-1:0] sel_color, commit_color, chk_code;
    logic               sample_match, counts_ok;

    always_comb begin
        sel_color    = (counter_q < SPLIT_IDX) ? edge_color_sensor : corner_color_sensor;
        sample_match = (sample_cnt_q == '0) || (sel_color == ref_q);
        commit_color = (sample_cnt_q == '0) ? sel_color : ref_q;
        retry_inc    = retry_q + 1'b1;
        chk_code     = stickers_q[int'(chk_idx_q)*COLOR_W +: COLOR_W];
        invalid_next = invalid_q | (chk_code > MAX_CODE);
        counts_ok    = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tally_next[c] = (chk_code == COLOR_W'(c)) ? tally_q[c] + 1'b1 : tally_q[c];
            if (tally_next[c] != PER_COLOR) counts_ok = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        stickers_d   = stickers_q;
        cube_d       = cube_q;
        determined_d = determined_q;
        error_d      = error_q;
        code_d       = code_q;
        timer_d      = timer_q;
        sample_cnt_d = sample_cnt_q;
        retry_d      = retry_q;
        ref_d        = ref_q;
        chk_idx_d    = chk_idx_q;
        invalid_d    = invalid_q;
        tally_d      = tally_q;
        case (state_q)
            ST_SETUP: begin
                counter_d    = '0;
                determined_d = 1'b0;
                error_d      = 1'b0;
                code_d       = 2'd0;
                stickers_d   = '0;
                retry_d      = '0;
                if (start) state_d = ST_PREP;
            end
            ST_PREP: begin
                timer_d = TMR_INIT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (color_sensor_stable) begin
                    state_d      = ST_SAMPLE;
                    sample_cnt_d = '0;
                end else if (timer_q == '0) begin
                    state_d = ST_ERROR;
                    error_d = 1'b1;
                    code_d  = 2'd1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (!color_sensor_stable) begin
                    state_d = ST_WAIT;
                    timer_d = TMR_INIT;
                end else if (!sample_match) begin
                    retry_d      = retry_inc;
                    sample_cnt_d = '0;
                    if (retry_inc == RTY_MAX) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                        code_d  = 2'd2;
                    end
                end else if (sample_cnt_q == SMP_LAST) begin
                    stickers_d = {stickers_q[STK_W-COLOR_W-1:0], commit_color};
                    counter_d  = counter_q + 1'b1;
                    retry_d    = '0;
                    state_d    = (counter_q == LAST_IDX) ? ST_FINAL : ST_PREP;
                end else begin
                    if (sample_cnt_q == '0) ref_d = sel_color;
                    sample_cnt_d = sample_cnt_q + 1'b1;
                end
            end
            ST_FINAL: begin
                state_d   = ST_CHECK;
                chk_idx_d = '0;
                invalid_d = 1'b0;
                for (int c = 0; c < 6; c++) tally_d[c] = '0;
            end
            ST_CHECK: begin
                tally_d   = tally_next;
                invalid_d = invalid_next;
                chk_idx_d = chk_idx_q + 1'b1;
                if (chk_idx_q == LAST_IDX) begin
                    if (invalid_next || !counts_ok) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                        code_d  = 2'd3;
                    end else begin
                        state_d      = ST_DONE;
                        cube_d       = {CENTRES, stickers_q};
                        determined_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                cube_d       = {CENTRES, stickers_q};
                determined_d = 1'b1;
                if (start) begin
                    state_d      = ST_SETUP;
                    determined_d = 1'b0;
                end
            end
            ST_ERROR: begin
                if (start) begin
                    state_d = ST_SETUP;
                    error_d = 1'b0;
                    code_d  = 2'd0;
                end
            end
            default: state_d = ST_SETUP;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_SETUP;
            counter_q    <= '0;
            stickers_q   <= '0;
            cube_q       <= '0;
            determined_q <= 1'b0;
            error_q      <= 1'b0;
            code_q       <= 2'd0;
            timer_q      <= '0;
            sample_cnt_q <= '0;
            retry_q      <= '0;
            ref_q        <= '0;
            chk_idx_q    <= '0;
            invalid_q    <= 1'b0;
            for (int c = 0; c < 6; c++) tally_q[c] <= '0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            stickers_q   <= stickers_d;
            cube_q       <= cube_d;
            determined_q <= determined_d;
            error_q      <= error_d;
            code_q       <= code_d;
            timer_q      <= timer_d;
            sample_cnt_q <= sample_cnt_d;
            retry_q      <= retry_d;
            ref_q        <= ref_d;
            chk_idx_q    <= chk_idx_d;
            invalid_q    <= invalid_d;
            for (int c = 0; c < 6; c++) tally_q[c] <= tally_d[c];
        end
    end

    // Pulses come straight from the one-cycle PREP/FINAL states, so reset kills them at once.
    assign send_setup_moves     = (state_q == ST_PREP) || (state_q == ST_FINAL);
    assign counter              = counter_q;
    assign cubestate_output     = cube_q;
    assign cubestate_determined = determined_q;
    assign scan_error           = error_q;
    assign error_code           = code_q;

endmodule

// File: tb/tb_scan_sequencer.sv
`timescale 1ns/1ps
// Randomized bench for scan_sequencer: a reactive sensor/motor environment plus a
// behavioural model of the expected cube state, pulse count and error outcome.
module tb_scan_sequencer;
    localparam int NUM_OBS     = 12;
    localparam int COLOR_W     = 3;
    localparam int SPLIT       = 6;
    localparam int SAMPLES     = 3;
    localparam int MAX_RETRIES = 4;
    localparam int TIMEOUT     = 100;
    localparam int CUBE_W      = (NUM_OBS+6)*COLOR_W;

    logic                clock, reset, start, color_sensor_stable;
    logic [COLOR_W-1:0]  edge_color_sensor, corner_color_sensor;
    logic                send_setup_moves;
    logic [3:0]          counter;
    logic [CUBE_W-1:0]   cubestate_output;
    logic                cubestate_determined, scan_error;
    logic [1:0]          error_code;

    int checks = 0;
    int failures = 0;
    int col [NUM_OBS];
    int flicker_idx, toggle_idx, timeout_idx, abort_idx, drop_idx;
    bit fixed_split;
    int pulses, consec, extra, last_pulse_cyc, end_cyc, cnt_at_abort;
    bit finished, aborted;
    logic [63:0] exp_out;

    scan_sequencer #(
        .NUM_OBS(NUM_OBS), .COLOR_W(COLOR_W), .SPLIT(SPLIT), .SAMPLES(SAMPLES),
        .MAX_RETRIES(MAX_RETRIES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .edge_color_sensor(edge_color_sensor), .corner_color_sensor(corner_color_sensor),
        .color_sensor_stable(color_sensor_stable), .send_setup_moves(send_setup_moves),
        .counter(counter), .cubestate_output(cubestate_output),
        .cubestate_determined(cubestate_determined), .scan_error(scan_error),
        .error_code(error_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Centres Y..W on top, then stickers in observation order (first observed is most significant).
    function automatic logic [63:0] model_cube();
        logic [63:0] r = '0;
        for (int c = 5; c >= 0; c--) r = (r << COLOR_W) | 64'(c);
        for (int i = 0; i < NUM_OBS; i++) r = (r << COLOR_W) | 64'(col[i]);
        return r;
    endfunction

    function automatic int model_code();
        int n [8];
        for (int c = 0; c < 8; c++) n[c] = 0;
        for (int i = 0; i < NUM_OBS; i++) n[col[i]]++;
        if (n[6] + n[7] > 0) return 3;
        for (int c = 0; c < 6; c++) if (n[c] != NUM_OBS/6) return 3;
        return 0;
    endfunction

    task automatic fill_valid();
        int j, t;
        for (int i = 0; i < NUM_OBS; i++) col[i] = i / (NUM_OBS/6);
        for (int i = NUM_OBS-1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = col[i]; col[i] = col[j]; col[j] = t;
        end
    endtask

    task automatic clear_modes();
        flicker_idx = -1; toggle_idx = -1; timeout_idx = -1; abort_idx = -1; drop_idx = -1;
        fixed_split = 1'b0;
    endtask

    task automatic run_scan();
        int cur = -1, delay = 0, age = 0, cyc = 0, v, other;
        bit stab = 1'b0, prev_pulse = 1'b0;
        pulses = 0; consec = 0; extra = 0; finished = 1'b0; aborted = 1'b0;
        last_pulse_cyc = 0; end_cyc = 0;
        start = 1'b1;
        while (cyc < 3000 && !finished) begin
            @(negedge clock);
            cyc++;
            if (send_setup_moves) begin
                pulses++;
                if (prev_pulse) consec++;
                start = 1'b0;
                last_pulse_cyc = cyc;
                cur = int'(counter);
                stab = 1'b0;
                delay = (cur == timeout_idx) ? -1 : int'($urandom_range(2, 7));
            end
            prev_pulse = send_setup_moves;
            if (pulses > 0 && (cubestate_determined || scan_error)) begin
                finished = 1'b1;
                end_cyc = cyc;
            end else begin
                if (stab) age++;
                else if (delay > 0) begin
                    delay--;
                    if (delay == 0) begin stab = 1'b1; age = 0; end
                end
                if (cur == abort_idx && stab && age == 2) begin
                    cnt_at_abort = int'(counter);
                    reset = 1'b0;
                    aborted = 1'b1;
                    finished = 1'b1;
                end else begin
                    v = 0;
                    if (cur >= 0 && cur < NUM_OBS) v = col[cur];
                    if (cur == flicker_idx && (age == 2 || age == 4)) v = v ^ 1;
                    if (cur == toggle_idx && (age % 2) == 1) v = v ^ 1;
                    other = (v + int'($urandom_range(1, 7))) % 8;
                    color_sensor_stable = stab && !(cur == drop_idx && age == 2);
                    if (!stab) begin
                        edge_color_sensor   = COLOR_W'($urandom);
                        corner_color_sensor = COLOR_W'($urandom);
                    end else if (fixed_split) begin
                        edge_color_sensor   = COLOR_W'(2);
                        corner_color_sensor = COLOR_W'(4);
                    end else if (cur < SPLIT) begin
                        edge_color_sensor   = COLOR_W'(v);
                        corner_color_sensor = COLOR_W'(other);
                    end else begin
                        edge_color_sensor   = COLOR_W'(other);
                        corner_color_sensor = COLOR_W'(v);
                    end
                end
            end
        end
        start = 1'b0;
        color_sensor_stable = 1'b0;
        if (finished && !aborted)
            repeat (6) begin
                @(negedge clock);
                if (send_setup_moves) extra++;
            end
    endtask

    task automatic verify(input string tag, input int exp_code, input int exp_pulses);
        check({tag, ".finished"}, 64'(finished), 64'd1);
        if (exp_code == 0) exp_out = model_cube();
        check({tag, ".pulses"}, 64'(pulses), 64'(exp_pulses));
        check({tag, ".back_to_back"}, 64'(consec), 64'd0);
        check({tag, ".pulse_after_end"}, 64'(extra), 64'd0);
        check({tag, ".determined"}, 64'(cubestate_determined), 64'(exp_code == 0));
        check({tag, ".scan_error"}, 64'(scan_error), 64'(exp_code != 0));
        check({tag, ".error_code"}, 64'(error_code), 64'(exp_code));
        check({tag, ".cube"}, 64'(cubestate_output), exp_out);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".send"}, 64'(send_setup_moves), 64'd0);
        check({tag, ".counter"}, 64'(counter), 64'd0);
        check({tag, ".cube"}, 64'(cubestate_output), 64'd0);
        check({tag, ".determined"}, 64'(cubestate_determined), 64'd0);
        check({tag, ".scan_error"}, 64'(scan_error), 64'd0);
        check({tag, ".error_code"}, 64'(error_code), 64'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; color_sensor_stable = 1'b0;
        edge_color_sensor = '0; corner_color_sensor = '0;
        exp_out = '0;
        clear_modes();
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;
        repeat (4) @(negedge clock);
        check("idle.send", 64'(send_setup_moves), 64'd0);
        check("idle.counter", 64'(counter), 64'd0);

        for (int i = 0; i < NUM_OBS; i++) col[i] = i / (NUM_OBS/6);
        run_scan();
        verify("clean", model_code(), NUM_OBS+1);

        clear_modes();
        fixed_split = 1'b1;
        for (int i = 0; i < NUM_OBS; i++) col[i] = (i < SPLIT) ? 2 : 4;
        run_scan();
        verify("split", model_code(), NUM_OBS+1);

        clear_modes();
        fill_valid();
        flicker_idx = 3;
        run_scan();
        verify("flicker", model_code(), NUM_OBS+1);

        clear_modes();
        fill_valid();
        toggle_idx = int'($urandom_range(0, NUM_OBS-1));
        run_scan();
        verify("retries", 2, toggle_idx+1);
        check("retries.counter", 64'(counter), 64'(toggle_idx));

        clear_modes();
        fill_valid();
        timeout_idx = 0;
        run_scan();
        verify("timeout", 1, 1);
        check("timeout.latency", 64'(end_cyc - last_pulse_cyc), 64'(TIMEOUT+1));

        clear_modes();
        fill_valid();
        abort_idx = 7;
        run_scan();
        check("abort.reached", 64'(aborted), 64'd1);
        check("abort.counter_before", 64'(cnt_at_abort), 64'd7);
        #1;
        check_all_zero("abort");
        exp_out = '0;
        @(negedge clock);
        check("abort.no_pulse", 64'(send_setup_moves), 64'd0);
        reset = 1'b1;
        clear_modes();
        @(negedge clock);
        fill_valid();
        run_scan();
        verify("restart", model_code(), NUM_OBS+1);

        start = 1'b1;
        @(negedge clock);
        check("rescan.determined_drop", 64'(cubestate_determined), 64'd0);
        fill_valid();
        run_scan();
        verify("rescan", model_code(), NUM_OBS+1);

        for (int k = 0; k < 6; k++) begin
            clear_modes();
            if ($urandom_range(0, 1) == 1) fill_valid();
            else for (int i = 0; i < NUM_OBS; i++) col[i] = int'($urandom_range(0, 7));
            drop_idx = int'($urandom_range(0, NUM_OBS-1));
            run_scan();
            verify($sformatf("rand%0d", k), model_code(), NUM_OBS+1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Parametrised successor to the cube-state scanner.
- Steps through NUM_OBS sticker observations. For each one it:
  - requests setup moves from the motor sequencer;
  - waits for a stable colour sensor;
  - debounces the reading over SAMPLES consecutive cycles;
  - shifts the colour into the packed cube-state register.
- Adds behaviour the previous scanner lacked: wait timeout, retry on unstable readings, colour-count validation, error reporting, and re-scan on a new start.
- Sits between the sensor front-end and the solver input.

Parameters:
- NUM_OBS, 48, number of non-centre stickers observed. Must be a multiple of 6.
- COLOR_W, 3, bits per colour code. Must be ≥3.
- SPLIT, 24, observations with index < SPLIT read sensor 0 (edge); the rest read sensor 1 (corner).
- SAMPLES, 3, consecutive identical reads required to commit a colour. Must be ≥1.
- MAX_RETRIES, 4, sample mismatches allowed per observation before error.
- TIMEOUT, 1000000, maximum cycles spent in WAIT per observation.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous, active-low reset.
- start, input, 1, level-sampled. Begins a scan from SETUP, DONE or ERROR.
- edge_color_sensor, input, COLOR_W, sensor 0 colour.
- corner_color_sensor, input, COLOR_W, sensor 1 colour.
- color_sensor_stable, input, 1, motors idle and sensor settled.
- send_setup_moves, output, 1, one-cycle pulse telling spin_all to issue the moves for the current counter.
- counter, output, clog2(NUM_OBS+1), current observation index.
- cubestate_output, output, (NUM_OBS+6)*COLOR_W, validated cube state.
- cubestate_determined, output, 1, high while cubestate_output is valid.
- scan_error, output, 1, high in ERROR.
- error_code, output, 2, error cause: 0 none, 1 timeout, 2 retries exhausted, 3 colour-count invalid.

Behaviour:
- Reset (reset low, async) sets: state SETUP, counter 0, send_setup_moves 0, cubestate_output 0, cubestate_determined 0, scan_error 0, error_code 0, internal shift register cleared to centres.
- Colour codes: W=0, O=1, G=2, Red=3, Blue=4, Y=5. Codes 6 and up are invalid.
- Internal register layout:
  - top 6*COLOR_W bits are the centres {Y,Blue,Red,G,O,W}, hardcoded;
  - lower NUM_OBS*COLOR_W bits hold stickers;
  - each commit shifts the sticker field left by COLOR_W and ORs the new colour into the LSBs;
  - centres are never shifted.
- SETUP: counter←0, determined←0, error←0, register←centres. If start, go to PREP.
- PREP: send_setup_moves←1 for exactly one cycle; timer←0; retry←0 only on first entry for an index; go to WAIT.
- WAIT:
  - send_setup_moves←0; timer increments each cycle.
  - If color_sensor_stable, go to SAMPLE with sample_cnt←0.
  - Else if timer==TIMEOUT-1, go to ERROR with code 1.
- SAMPLE:
  - Selected sensor is edge_color_sensor if counter<SPLIT, else corner_color_sensor.
  - Cycle 0 latches the reference colour. Each later cycle compares against it.
  - If stable drops: return to WAIT with timer←0.
  - On mismatch: retry increments and sampling restarts. If retry reaches MAX_RETRIES, go to ERROR with code 2.
  - After SAMPLES matching reads: commit the colour and increment counter.
  - Next state is PREP if the new counter<NUM_OBS, else FINAL.
  - Latency from stable to commit is SAMPLES cycles.
- FINAL: one send_setup_moves pulse with counter==NUM_OBS (restore moves), then go to CHECK.
- CHECK:
  - One sticker per cycle, NUM_OBS cycles.
  - Six per-colour counters increment; an invalid-code flag is set on any code >5.
  - At the end: if any count ≠ NUM_OBS/6 or the invalid flag is set, go to ERROR with code 3. Otherwise go to DONE.
- DONE:
  - cubestate_output←register; cubestate_determined←1.
  - Holds. start returns to SETUP (determined drops the next cycle).
- ERROR:
  - scan_error=1 and error_code held; cubestate_output unchanged; no send_setup_moves pulses.
  - start returns to SETUP.
- start is ignored in all other states.
- send_setup_moves is never high for two consecutive cycles.
- Asserting reset mid-scan aborts immediately; no further pulses are issued.

Test Plan:
- Clean scan: NUM_OBS=12, SAMPLES=3; sensors give 0,0,1,1,…,5,5 with stable asserted 5 cycles after each pulse -> 13 send_setup_moves pulses; cubestate_determined=1; cubestate_output = {5,4,3,2,1,0, 0,0,1,1,2,2,3,3,4,4,5,5}; error_code=0.
- Sensor split: SPLIT=6, edge sensor fixed at 2, corner sensor fixed at 4 -> stickers 0–5 read 2 and 6–11 read 4 -> count check fails -> scan_error=1, error_code=3.
- Flicker: at index 3, colour toggles on the 2nd sample twice and then holds -> 2 retries; commit succeeds; scan completes with error_code=0.
- Retries exhausted: MAX_RETRIES=4 and the colour toggles every cycle -> ERROR, error_code=2, counter frozen at the failing index.
- Timeout: TIMEOUT=100 and stable never asserts after the first pulse -> ERROR exactly 100 cycles after entering WAIT; error_code=1.
- Reset and restart: reset asserted low mid-SAMPLE at counter=7 -> all outputs 0 the same cycle; after release, start reruns the full scan; start in DONE re-scans and cubestate_determined drops within 1 cycle.
